// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared constants for the 7-segment scan capture block.
// Segment patterns are active-low: bit7=dp, bits6..0 = g,f,e,d,c,b,a.
package seg_scan_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Hex digit patterns with the decimal point off
    localparam logic [7:0] HEX_0 = 8'hC0;
    localparam logic [7:0] HEX_1 = 8'hF9;
    localparam logic [7:0] HEX_2 = 8'hA4;
    localparam logic [7:0] HEX_3 = 8'hB0;
    localparam logic [7:0] HEX_4 = 8'h99;
    localparam logic [7:0] HEX_5 = 8'h92;
    localparam logic [7:0] HEX_6 = 8'h82;
    localparam logic [7:0] HEX_7 = 8'hF8;
    localparam logic [7:0] HEX_8 = 8'h80;
    localparam logic [7:0] HEX_9 = 8'h90;
    localparam logic [7:0] HEX_A = 8'h88;
    localparam logic [7:0] HEX_B = 8'h83;
    localparam logic [7:0] HEX_C = 8'hC6;
    localparam logic [7:0] HEX_D = 8'hA1;
    localparam logic [7:0] HEX_E = 8'h86;
    localparam logic [7:0] HEX_F = 8'h8E;

    // All segments dark; decodes as nibble 0 without error
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } seg_state_t;

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: maps a 7-bit active-low segment pattern back to a hex nibble.
// o_hit is low when the pattern is not one the display driver can produce.
module seg_hex_decode
    import seg_scan_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_nibble,
    output logic       o_hit
);

    // Reverse lookup of the hex table; a dark digit reads back as zero
    always_comb begin
        o_nibble = 4'h0;
        o_hit    = 1'b1;
        case (i_pattern)
            HEX_0[6:0]:     o_nibble = 4'h0;
            HEX_1[6:0]:     o_nibble = 4'h1;
            HEX_2[6:0]:     o_nibble = 4'h2;
            HEX_3[6:0]:     o_nibble = 4'h3;
            HEX_4[6:0]:     o_nibble = 4'h4;
            HEX_5[6:0]:     o_nibble = 4'h5;
            HEX_6[6:0]:     o_nibble = 4'h6;
            HEX_7[6:0]:     o_nibble = 4'h7;
            HEX_8[6:0]:     o_nibble = 4'h8;
            HEX_9[6:0]:     o_nibble = 4'h9;
            HEX_A[6:0]:     o_nibble = 4'hA;
            HEX_B[6:0]:     o_nibble = 4'hB;
            HEX_C[6:0]:     o_nibble = 4'hC;
            HEX_D[6:0]:     o_nibble = 4'hD;
            HEX_E[6:0]:     o_nibble = 4'hE;
            HEX_F[6:0]:     o_nibble = 4'hF;
            SEG_BLANK[6:0]: o_nibble = 4'h0;
            default:        o_hit    = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: samples the scanned digit-select and segment pins and
// rebuilds the displayed hex word plus decimal points, one frame at a time.
// Optional feature macro: SEG_CAPTURE_CHANGE_EN (adds the value_changed pulse).
module seg_scan_capture
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_DIGITS-1:0]   figure,
    input  logic [7:0]              seg_signal,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_valid,
    output logic                    decode_err,
    output logic [2:0]              err_digit,
    output logic                    value_changed
);

    localparam int         IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [3:0] STABLE_CNT = 4'(STABLE_CYCLES);
    localparam bit         ONE_SHOT   = (STABLE_CYCLES == 1);

    logic [NUM_DIGITS-1:0]   r_fig_s1, r_fig_s2;
    logic [7:0]              r_seg_s1, r_seg_s2;
    seg_state_t              r_state, w_next_state;
    logic [IDX_W-1:0]        r_lat_idx;
    logic [7:0]              r_lat_seg;
    logic [3:0]              r_cnt;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [NUM_DIGITS-1:0]   r_dp_shadow;
    logic [NUM_DIGITS-1:0]   r_digit_valid;
    logic [4*NUM_DIGITS-1:0] r_value;
    logic [NUM_DIGITS-1:0]   r_dp_mask;
    logic                    r_frame_valid;
    logic                    r_decode_err;
    logic [2:0]              r_err_digit;

    logic [NUM_DIGITS-1:0]   w_fig_low;
    logic                    w_sel_ok;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_match;
    logic [3:0]              w_cnt_inc;
    logic                    w_load;
    logic                    w_inc;
    logic                    w_capture;
    logic [3:0]              w_nibble;
    logic                    w_hit;
    logic [4*NUM_DIGITS-1:0] w_shadow_next;
    logic [NUM_DIGITS-1:0]   w_dp_next;
    logic [NUM_DIGITS-1:0]   w_dv_next;
    logic                    w_frame_done;

    // Two-flop synchronisers on the display pins
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fig_s1 <= '0;
            r_fig_s2 <= '0;
            r_seg_s1 <= '0;
            r_seg_s2 <= '0;
        end else begin
            r_fig_s1 <= figure;
            r_fig_s2 <= r_fig_s1;
            r_seg_s1 <= seg_signal;
            r_seg_s2 <= r_seg_s1;
        end
    end

    // One low select bit is a lit digit; none or several low is blanking
    always_comb begin
        w_fig_low = ~r_fig_s2;
        w_sel_ok  = (w_fig_low != '0) &&
                    ((w_fig_low & (w_fig_low - NUM_DIGITS'(1))) == '0);
        w_idx     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_fig_low[i]) begin
                w_idx = IDX_W'(i);
            end
        end
        w_match   = (w_idx == r_lat_idx) && (r_seg_s2 == r_lat_seg);
        w_cnt_inc = r_cnt + 4'd1;
    end

    seg_hex_decode u_decode (
        .i_pattern (r_seg_s2[6:0]),
        .o_nibble  (w_nibble),
        .o_hit     (w_hit)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Debounce FSM: a digit must hold index and pattern for STABLE_CYCLES samples
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_inc        = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sel_ok) begin
                    w_load       = 1'b1;
                    w_capture    = ONE_SHOT;
                    w_next_state = ONE_SHOT ? HOLD : SETTLE;
                end
            end
            SETTLE: begin
                if (!w_sel_ok) begin
                    w_next_state = IDLE;
                end else if (w_match) begin
                    w_inc = 1'b1;
                    if (w_cnt_inc == STABLE_CNT) begin
                        w_capture    = 1'b1;
                        w_next_state = HOLD;
                    end
                end else begin
                    w_load    = 1'b1;
                    w_capture = ONE_SHOT;
                    if (ONE_SHOT) begin
                        w_next_state = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!w_sel_ok) begin
                    w_next_state = IDLE;
                end else if (!w_match) begin
                    w_load       = 1'b1;
                    w_capture    = ONE_SHOT;
                    w_next_state = ONE_SHOT ? HOLD : SETTLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Shadow frame as it would look after writing the current digit
    always_comb begin
        w_shadow_next                  = r_shadow;
        w_shadow_next[w_idx*4 +: 4]    = w_nibble;
        w_dp_next                      = r_dp_shadow;
        w_dp_next[w_idx]               = ~r_seg_s2[SEG_DP];
        w_dv_next                      = r_digit_valid;
        w_dv_next[w_idx]               = 1'b1;
        w_frame_done                   = w_capture && w_hit && (&w_dv_next);
    end

    // Latch/count, capture into the shadow, and publish completed frames
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lat_idx     <= '0;
            r_lat_seg     <= '0;
            r_cnt         <= '0;
            r_shadow      <= '0;
            r_dp_shadow   <= '0;
            r_digit_valid <= '0;
            r_value       <= '0;
            r_dp_mask     <= '0;
            r_frame_valid <= 1'b0;
            r_decode_err  <= 1'b0;
            r_err_digit   <= '0;
        end else begin
            r_frame_valid <= 1'b0;
            r_decode_err  <= 1'b0;
            if (w_load) begin
                r_lat_idx <= w_idx;
                r_lat_seg <= r_seg_s2;
                r_cnt     <= 4'd1;
            end else if (w_inc) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_capture) begin
                if (w_hit) begin
                    r_shadow    <= w_shadow_next;
                    r_dp_shadow <= w_dp_next;
                    if (w_frame_done) begin
                        r_value       <= w_shadow_next;
                        r_dp_mask     <= w_dp_next;
                        r_frame_valid <= 1'b1;
                        r_digit_valid <= '0;
                    end else begin
                        r_digit_valid <= w_dv_next;
                    end
                end else begin
                    r_decode_err <= 1'b1;
                    r_err_digit  <= 3'(w_idx);
                end
            end
        end
    end

`ifdef SEG_CAPTURE_CHANGE_EN
    logic [4*NUM_DIGITS-1:0] r_prev_value;
    logic [NUM_DIGITS-1:0]   r_prev_dp;
    logic                    r_have_prev;
    logic                    r_value_changed;

    // Compare each new frame to the previous one; the first frame always counts as a change
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_value    <= '0;
            r_prev_dp       <= '0;
            r_have_prev     <= 1'b0;
            r_value_changed <= 1'b0;
        end else begin
            r_value_changed <= 1'b0;
            if (w_frame_done) begin
                r_value_changed <= !r_have_prev ||
                                   (w_shadow_next != r_prev_value) ||
                                   (w_dp_next != r_prev_dp);
                r_prev_value    <= w_shadow_next;
                r_prev_dp       <= w_dp_next;
                r_have_prev     <= 1'b1;
            end
        end
    end

    assign value_changed = r_value_changed;
`else
    assign value_changed = 1'b0;
`endif

    assign value       = r_value;
    assign dp_mask     = r_dp_mask;
    assign digit_valid = r_digit_valid;
    assign frame_valid = r_frame_valid;
    assign decode_err  = r_decode_err;
    assign err_digit   = r_err_digit;

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: drives scanned display patterns into seg_scan_capture
// and checks every reconstructed frame and decode error against expectations.
module tb_seg_scan_capture;

    typedef struct {
        logic [31:0] v;
        logic [7:0]  dp;
        logic        ch;
    } frameExp_t;

    logic        clk;
    logic        reset;
    logic [7:0]  figure;
    logic [7:0]  segSignal;
    logic [31:0] value;
    logic [7:0]  dpMask;
    logic [7:0]  digitValid;
    logic        frameValid;
    logic        decodeErr;
    logic [2:0]  errDigit;
    logic        valueChanged;

    int vectors = 0;
    int miscompares = 0;

    frameExp_t   frameQ[$];
    logic [2:0]  errQ[$];

    // Active-low hex patterns, dp off, written out by hand
    logic [7:0] hexPat [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seg_scan_capture #(.NUM_DIGITS(8), .STABLE_CYCLES(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .figure        (figure),
        .seg_signal    (segSignal),
        .value         (value),
        .dp_mask       (dpMask),
        .digit_valid   (digitValid),
        .frame_valid   (frameValid),
        .decode_err    (decodeErr),
        .err_digit     (errDigit),
        .value_changed (valueChanged)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] sel(input int idx);
        logic [7:0] one;
        one = 8'd1;
        return ~(one << idx);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] fig, input logic [7:0] seg, input int n);
        figure    = fig;
        segSignal = seg;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic expChanged(input logic c);
`ifdef SEG_CAPTURE_CHANGE_EN
        return c;
`else
        return 1'b0;
`endif
    endfunction

    task automatic pushFrame(input logic [31:0] v, input logic [7:0] dp, input logic c);
        frameExp_t e;
        e.v  = v;
        e.dp = dp;
        e.ch = expChanged(c);
        frameQ.push_back(e);
    endtask

    // Monitor: pops an expectation whenever the DUT signals a frame or an error
    always @(negedge clk) begin
        if (!reset) begin
            if (frameValid) begin
                if (frameQ.size() == 0) begin
                    checkOutput("unexpectedFrame", 32'd1, 32'd0);
                end else begin
                    frameExp_t e;
                    e = frameQ.pop_front();
                    checkOutput("frameValue", value, e.v);
                    checkOutput("frameDpMask", {24'd0, dpMask}, {24'd0, e.dp});
                    checkOutput("frameValueChanged", {31'd0, valueChanged}, {31'd0, e.ch});
                end
            end else if (valueChanged) begin
                checkOutput("strayValueChanged", 32'd1, 32'd0);
            end
            if (decodeErr) begin
                if (errQ.size() == 0) begin
                    checkOutput("unexpectedDecodeErr", 32'd1, 32'd0);
                end else begin
                    logic [2:0] d;
                    d = errQ.pop_front();
                    checkOutput("errDigit", {29'd0, errDigit}, {29'd0, d});
                end
            end
        end
    end

    initial begin
        logic [7:0] dpFrame [8];
        reset     = 1'b1;
        figure    = 8'hFF;
        segSignal = 8'hFF;
        repeat (3) @(posedge clk);
        #1;

        checkOutput("resetValue", value, 32'd0);
        checkOutput("resetDpMask", {24'd0, dpMask}, 32'd0);
        checkOutput("resetDigitValid", {24'd0, digitValid}, 32'd0);
        checkOutput("resetFrameValid", {31'd0, frameValid}, 32'd0);
        checkOutput("resetDecodeErr", {31'd0, decodeErr}, 32'd0);
        checkOutput("resetErrDigit", {29'd0, errDigit}, 32'd0);
        checkOutput("resetValueChanged", {31'd0, valueChanged}, 32'd0);
        reset = 1'b0;
        applyStimulus(8'hFF, 8'hFF, 4);

        // Steady frame 0..7
        pushFrame(32'h76543210, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(sel(i), hexPat[i], 8);
        applyStimulus(8'hFF, 8'hFF, 6);
        checkOutput("steadyDigitValidCleared", {24'd0, digitValid}, 32'd0);
        checkOutput("valueHoldsBetweenFrames", value, 32'h76543210);

        // Glitch on digit 2: 8 for 3 cycles is rejected, A is kept
        pushFrame(32'h76543A10, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                applyStimulus(sel(2), hexPat[8], 3);
                applyStimulus(sel(2), hexPat[10], 8);
            end else begin
                applyStimulus(sel(i), hexPat[i], 8);
            end
        end
        applyStimulus(8'hFF, 8'hFF, 6);

        // Decimal point on digit 5, dark digit 6
        dpFrame = '{hexPat[1], hexPat[2], hexPat[3], hexPat[4], hexPat[9], 8'h00, 8'hFF, hexPat[12]};
        pushFrame(32'hC0894321, 8'h20, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(sel(i), dpFrame[i], 8);
        applyStimulus(8'hFF, 8'hFF, 6);

        // Undecodable pattern on digit 3 holds off the frame until repaired
        errQ.push_back(3'd3);
        for (int i = 0; i < 3; i++) applyStimulus(sel(i), hexPat[15], 8);
        applyStimulus(sel(3), 8'hAA, 8);
        applyStimulus(8'hFF, 8'hFF, 6);
        checkOutput("badDigitValid", {24'd0, digitValid}, 32'h07);
        checkOutput("badErrDigitHeld", {29'd0, errDigit}, 32'd3);
        for (int i = 4; i < 8; i++) applyStimulus(sel(i), hexPat[15], 8);
        applyStimulus(8'hFF, 8'hFF, 6);
        checkOutput("missingDigit3", {24'd0, digitValid}, 32'hF7);
        pushFrame(32'hFFFF1FFF, 8'h00, 1'b1);
        applyStimulus(sel(3), hexPat[1], 8);
        applyStimulus(8'hFF, 8'hFF, 6);
        checkOutput("repairedDigitValid", {24'd0, digitValid}, 32'd0);

        // Overlapping selects and blanking between digits never capture
        pushFrame(32'h10FEDCBA, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(sel(i), hexPat[(i + 10) % 16], 8);
            applyStimulus(8'hFC, hexPat[8], 6);
            applyStimulus(8'hFF, hexPat[8], 3);
        end
        applyStimulus(8'hFF, 8'hFF, 6);

        // Reset after five digits discards the partial frame
        for (int i = 0; i < 5; i++) applyStimulus(sel(i), hexPat[2], 8);
        applyStimulus(8'hFF, 8'hFF, 4);
        checkOutput("partialDigitValid", {24'd0, digitValid}, 32'h1F);
        reset = 1'b1;
        applyStimulus(8'hFF, 8'hFF, 2);
        reset = 1'b0;
        checkOutput("midResetValue", value, 32'd0);
        checkOutput("midResetDpMask", {24'd0, dpMask}, 32'd0);
        checkOutput("midResetDigitValid", {24'd0, digitValid}, 32'd0);
        applyStimulus(8'hFF, 8'hFF, 3);

        pushFrame(32'hFFFFFFFF, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(sel(i), hexPat[15], 8);
        applyStimulus(8'hFF, 8'hFF, 6);

        // Identical frame again: no change reported
        pushFrame(32'hFFFFFFFF, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(sel(i), hexPat[15], 8);
        applyStimulus(8'hFF, 8'hFF, 6);

        for (int i = 0; i < 200 && (frameQ.size() != 0 || errQ.size() != 0); i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("pendingFrames", frameQ.size(), 32'd0);
        checkOutput("pendingErrors", errQ.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
